// File: rtl/clk_enable_bank.sv
// Bank of independently programmable clock-enable generators sharing one clock.
// Each channel emits a one-cycle ce pulse every 2^prog cycles while running.
module clk_enable_bank #(
  parameter int N_CH       = 2,
  parameter int PROG_W     = 3,
  parameter int CNT_W      = 8,
  parameter int RESET_PROG = 0,
  parameter int RESYNC     = 1,
  parameter int SEL_W      = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     update,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic [PROG_W-1:0]        prog,
  input  logic [N_CH-1:0]          start,
  input  logic [N_CH-1:0]          stop,
  output logic [N_CH-1:0]          ce,
  output logic [N_CH-1:0]          running,
  output logic [N_CH*PROG_W-1:0]   cur_prog,
  output logic                     upd_err
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e              state_q [N_CH];
  state_e              state_d [N_CH];
  logic [CNT_W-1:0]    cnt_q   [N_CH];
  logic [CNT_W-1:0]    cnt_d   [N_CH];
  logic [PROG_W-1:0]   pend_q  [N_CH];
  logic [PROG_W-1:0]   pend_d  [N_CH];
  logic [PROG_W-1:0]   act_q   [N_CH];
  logic [PROG_W-1:0]   act_d   [N_CH];
  logic [N_CH-1:0]     ce_q, ce_d;
  logic [N_CH-1:0]     upd_hit;
  logic                upd_err_q, upd_err_d;
  logic                upd_valid;

  assign upd_valid = update && (int'(ch_sel) < N_CH);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    upd_err_d = update && !upd_valid;
    upd_hit   = '0;
    ce_d      = '0;
    for (int i = 0; i < N_CH; i++) begin
      upd_hit[i] = upd_valid && (int'(ch_sel) == i);
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      act_d[i]   = act_q[i];
      pend_d[i]  = upd_hit[i] ? prog : pend_q[i];

      // Priority: stop, start, resync update, then normal counting.
      if (stop[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else if (start[i]) begin
        state_d[i] = ST_RUN;
        cnt_d[i]   = '0;
        act_d[i]   = pend_d[i];
      end else if (state_q[i] == ST_RUN) begin
        if ((RESYNC != 0) && upd_hit[i]) begin
          cnt_d[i] = '0;
          act_d[i] = prog;
        end else if (cnt_q[i] == ((CNT_W'(1) << act_q[i]) - CNT_W'(1))) begin
          cnt_d[i] = '0;
          ce_d[i]  = 1'b1;
          // Apply-at-wrap: the wrap uses the old ratio, the next period the new one.
          if (RESYNC == 0) act_d[i] = pend_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the per-channel arrays are control state, not storage, so every entry is reset.
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= PROG_W'(RESET_PROG);
        act_q[i]   <= PROG_W'(RESET_PROG);
      end
      ce_q      <= '0;
      upd_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pend_q[i]  <= pend_d[i];
        act_q[i]   <= act_d[i];
      end
      ce_q      <= ce_d;
      upd_err_q <= upd_err_d;
    end
  end

  always_comb begin
    running  = '0;
    cur_prog = '0;
    for (int i = 0; i < N_CH; i++) begin
      running[i]                    = (state_q[i] == ST_RUN);
      cur_prog[i*PROG_W +: PROG_W]  = pend_q[i];
    end
  end

  assign ce      = ce_q;
  assign upd_err = upd_err_q;

endmodule

// File: tb/tb_clk_enable_bank.sv
// Directed bench for clk_enable_bank: one instance in resync-immediate mode,
// one in apply-at-wrap mode, both with a 2-bit channel select.
module tb_clk_enable_bank;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       upd_r, upd_w, err_r, err_w;
  logic [1:0] sel_r, sel_w, start_r, start_w, stop_r, stop_w;
  logic [1:0] ce_r, ce_w, run_r, run_w;
  logic [2:0] prog_r, prog_w;
  logic [5:0] cp_r, cp_w;

  clk_enable_bank #(.N_CH(2), .PROG_W(3), .CNT_W(8), .RESET_PROG(0), .RESYNC(1), .SEL_W(2)) dut_r (
    .clock(clock), .reset(reset), .update(upd_r), .ch_sel(sel_r), .prog(prog_r),
    .start(start_r), .stop(stop_r), .ce(ce_r), .running(run_r), .cur_prog(cp_r), .upd_err(err_r)
  );

  clk_enable_bank #(.N_CH(2), .PROG_W(3), .CNT_W(8), .RESET_PROG(0), .RESYNC(0), .SEL_W(2)) dut_w (
    .clock(clock), .reset(reset), .update(upd_w), .ch_sel(sel_w), .prog(prog_w),
    .start(start_w), .stop(stop_w), .ce(ce_w), .running(run_w), .cur_prog(cp_w), .upd_err(err_w)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    upd_r = 1'b0; sel_r = '0; prog_r = '0; start_r = '0; stop_r = '0;
    upd_w = 1'b0; sel_w = '0; prog_w = '0; start_w = '0; stop_w = '0;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Let the driven strobes be sampled by one rising edge, then drop them.
  task automatic advance();
    step();
    clear_strobes();
  endtask

  // Negedges until ce[ch] is seen high; lim+1 means it never came.
  task automatic gap(input bit on_w, input int ch, input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(on_w ? ce_w[ch] : ce_r[ch]) && n <= lim);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0] seen;
    clear_strobes();
    reset = 1'b0;
    repeat (3) step();
    check("rst_ce", ce_r, 0);
    check("rst_running", run_r, 0);
    check("rst_cur_prog", cp_r, 0);
    check("rst_upd_err", err_r, 0);
    check("rst_ce_w", ce_w, 0);
    reset = 1'b1;
    step();

    // Default ratio 0: continuous enable on channel 0.
    start_r = 2'b01; advance();
    check("start_running", run_r, 2'b01);
    check("start_ce_low", ce_r, 0);
    gap(0, 0, 20, n);
    check("div1_first", n, 1);
    repeat (3) begin
      step();
      check("div1_steady", ce_r, 2'b01);
    end
    check("def_cur_prog", cp_r, 0);

    // Resync-immediate update to ratio 3.
    upd_r = 1'b1; sel_r = 2'd0; prog_r = 3'd3; advance();
    check("resync_ce_low", ce_r[0], 0);
    check("resync_cur_prog", cp_r, 6'o03);
    gap(0, 0, 20, n); check("resync_first", n, 8);
    gap(0, 0, 20, n); check("resync_period", n, 8);

    // Channel 1: idle update, start, stop mid-period, restart at ratio 5.
    upd_r = 1'b1; sel_r = 2'd1; prog_r = 3'd2; advance();
    check("idle_upd_no_run", run_r[1], 0);
    check("idle_upd_cur_prog", cp_r, 6'o23);
    start_r = 2'b10; advance();
    gap(0, 1, 20, n); check("ch1_div4", n, 4);
    step(); step();
    stop_r = 2'b10; advance();
    check("stop_running", run_r[1], 0);
    check("stop_ce", ce_r[1], 0);
    upd_r = 1'b1; sel_r = 2'd1; prog_r = 3'd5; advance();
    start_r = 2'b10; advance();
    gap(0, 1, 60, n); check("restart_div32", n, 32);
    check("restart_cur_prog", cp_r, 6'o53);

    // Start and update together: new ratio writes through to act.
    start_r = 2'b10; upd_r = 1'b1; sel_r = 2'd1; prog_r = 3'd1; advance();
    gap(0, 1, 20, n); check("start_upd_write_through", n, 2);
    check("start_upd_cur_prog", cp_r, 6'o13);

    // Out-of-range update mid-period on channel 0 (ratio 3).
    gap(0, 0, 20, n); check("ch0_period_bg", n <= 8, 1);
    repeat (3) step();
    upd_r = 1'b1; sel_r = 2'd3; prog_r = 3'd7; advance();
    check("upd_err_pulse", err_r, 1);
    check("upd_err_cur_prog", cp_r, 6'o13);
    step();
    check("upd_err_once", err_r, 0);
    gap(0, 0, 20, n); check("upd_err_spacing", n, 3);
    gap(0, 0, 20, n); check("upd_err_period", n, 8);

    // Start and stop together: stop wins.
    start_r = 2'b01; stop_r = 2'b01; advance();
    check("startstop_running", run_r[0], 0);
    check("startstop_ce", ce_r[0], 0);
    seen = '0;
    repeat (10) begin step(); seen |= ce_r & 2'b01; end
    check("startstop_no_ce", seen, 0);
    check("startstop_stays_idle", run_r[0], 0);

    // Apply-at-wrap instance: ratio 2, update to 4 while cnt=1.
    upd_w = 1'b1; sel_w = 2'd0; prog_w = 3'd2; advance();
    start_w = 2'b01; advance();
    gap(1, 0, 20, n); check("wrap_div4", n, 4);
    step();
    upd_w = 1'b1; sel_w = 2'd0; prog_w = 3'd4; advance();
    gap(1, 0, 20, n); check("wrap_old_period", n, 2);
    gap(1, 0, 40, n); check("wrap_new_period", n, 16);
    check("wrap_cur_prog", cp_w, 6'o04);

    // Ratio 0 on channel 0 and maximum ratio 7 on channel 1, then reset.
    upd_r = 1'b1; sel_r = 2'd0; prog_r = 3'd0; advance();
    start_r = 2'b01; upd_r = 1'b1; sel_r = 2'd1; prog_r = 3'd7; advance();
    gap(0, 1, 200, n); check("max_ratio_div128", n, 128);
    check("both_ce_high", ce_r, 2'b11);
    reset = 1'b0; step();
    check("midrst_ce", ce_r, 0);
    check("midrst_running", run_r, 0);
    check("midrst_cur_prog", cp_r, 0);
    check("midrst_upd_err", err_r, 0);
    check("midrst_ce_w", ce_w, 0);
    check("midrst_cur_prog_w", cp_w, 0);
    reset = 1'b1;
    seen = '0;
    repeat (200) begin step(); seen |= ce_r | ce_w; end
    check("no_ce_after_reset", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
